n_bit_comparator: RTL and testbench

Registered magnitude comparator for two N-bit operands. Produces one-hot lesser/greater/equal flags one clock after a valid input sample. Used as a leaf compare unit in datapath and control logic wherever a clean, registered compare result with a valid qualifier is needed.

---
 rtl/n_bit_comparator.sv | 68 ++++++
 tb/tb_n_bit_comparator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_comparator.sv
// Registered magnitude comparator: one-hot lesser/greater/equal one cycle after in_valid.
// Optional macro N_BIT_COMPARATOR_DIFF_EN adds a registered |a-b| output (diff).
module n_bit_comparator #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             lesser,
  output logic             greater,
`ifdef N_BIT_COMPARATOR_DIFF_EN
  output logic [WIDTH-1:0] diff,
`endif
  output logic             equal
);

  logic [WIDTH:0] a_ext, b_ext, sub;
  logic           lt, gt, eq;

  // One extra bit makes the subtraction overflow-free in both modes.
  generate
    if (SIGNED != 0) begin : g_signed
      assign a_ext = {a[WIDTH-1], a};
      assign b_ext = {b[WIDTH-1], b};
    end else begin : g_unsigned
      assign a_ext = {1'b0, a};
      assign b_ext = {1'b0, b};
    end
  endgenerate

  assign sub = a_ext - b_ext;
  assign eq  = (sub == '0);
  assign lt  = sub[WIDTH];
  assign gt  = ~lt & ~eq;

`ifdef N_BIT_COMPARATOR_DIFF_EN
  logic [WIDTH:0] mag;

  // Largest magnitude is 2^WIDTH-1 in either mode, so the top bit is always 0.
  assign mag = lt ? (~sub + 1'b1) : sub;

  always_ff @(posedge clk) begin
    if (rst) diff <= '0;
    else if (in_valid) diff <= mag[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      lesser    <= 1'b0;
      greater   <= 1'b0;
      equal     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        lesser  <= lt;
        greater <= gt;
        equal   <= eq;
      end
    end
  end

endmodule

// File: tb/tb_n_bit_comparator.sv
// Self-checking bench: unsigned and signed 8-bit instances against an integer-arithmetic model.
module tb_n_bit_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       u_ov, u_lt, u_gt, u_eq;
  logic       s_ov, s_lt, s_gt, s_eq;
`ifdef N_BIT_COMPARATOR_DIFF_EN
  logic [7:0] u_diff, s_diff;
`endif

  int checks = 0, passes = 0;

  // Model state: {out_valid, lesser, greater, equal} and held diff per instance.
  logic [3:0] exp_u = '0, exp_s = '0;
  logic [7:0] exd_u = '0, exd_s = '0;

  always #5 clk = ~clk;

  n_bit_comparator #(.WIDTH(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(u_ov), .lesser(u_lt), .greater(u_gt),
`ifdef N_BIT_COMPARATOR_DIFF_EN
    .diff(u_diff),
`endif
    .equal(u_eq));

  n_bit_comparator #(.WIDTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(s_ov), .lesser(s_lt), .greater(s_gt),
`ifdef N_BIT_COMPARATOR_DIFF_EN
    .diff(s_diff),
`endif
    .equal(s_eq));

  // Returns {lt, gt, eq, |a-b|[7:0]} from plain integer arithmetic.
  function automatic logic [10:0] golden(input bit sgn, input logic [7:0] x, input logic [7:0] y);
    longint xv, yv, df, mag;
    xv  = sgn ? longint'($signed(x)) : longint'({56'd0, x});
    yv  = sgn ? longint'($signed(y)) : longint'({56'd0, y});
    df  = xv - yv;
    mag = (df < 0) ? -df : df;
    return {df < 0, df > 0, df == 0, mag[7:0]};
  endfunction

  task automatic model_edge();
    logic [10:0] gu, gs;
    if (rst) begin
      exp_u = '0; exp_s = '0; exd_u = '0; exd_s = '0;
    end else begin
      exp_u[3] = in_valid;
      exp_s[3] = in_valid;
      if (in_valid) begin
        gu = golden(1'b0, a, b);
        gs = golden(1'b1, a, b);
        exp_u[2:0] = gu[10:8]; exd_u = gu[7:0];
        exp_s[2:0] = gs[10:8]; exd_s = gs[7:0];
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({u_ov, u_lt, u_gt, u_eq} !== 4'b0000 || {s_ov, s_lt, s_gt, s_eq} !== 4'b0000)
        $display("FAIL reset[%0d] got u=%b s=%b want 0000", i, {u_ov, u_lt, u_gt, u_eq}, {s_ov, s_lt, s_gt, s_eq});
      else passes++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({u_ov, u_lt, u_gt, u_eq} !== 4'b1001)
      $display("FAIL reset_first_result got %b want 1001", {u_ov, u_lt, u_gt, u_eq});
    else passes++;
  endtask

  task automatic test_unsigned_seq();
    logic [7:0] av[10] = '{111, 147, 199, 137, 255, 169, 85, 21, 79, 96};
    logic [7:0] bv[10] = '{250, 103, 220, 171, 255, 169, 25, 50, 74, 96};
    string      want   = "LGLLEEGLGE";
    logic [3:0] cv;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = av[i]; b = bv[i];
      tick();
      cv = (want[i] == "L") ? 4'b1100 : (want[i] == "G") ? 4'b1010 : 4'b1001;
      checks++;
      if ({u_ov, u_lt, u_gt, u_eq} !== cv || exp_u !== cv)
        $display("FAIL unsigned_seq[%0d] got %b model %b want %b", i, {u_ov, u_lt, u_gt, u_eq}, exp_u, cv);
      else passes++;
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] av[3] = '{8'd0, 8'd0, 8'd255};
    logic [7:0] bv[3] = '{8'd0, 8'd255, 8'd0};
    logic [3:0] cv[3] = '{4'b1001, 4'b1100, 4'b1010};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = av[i]; b = bv[i];
      tick();
      checks++;
      if ({u_ov, u_lt, u_gt, u_eq} !== cv[i])
        $display("FAIL boundary[%0d] got %b want %b", i, {u_ov, u_lt, u_gt, u_eq}, cv[i]);
      else passes++;
      checks++;
      if ($countones({u_lt, u_gt, u_eq}) != 1 || $countones({s_lt, s_gt, s_eq}) != 1)
        $display("FAIL boundary_onehot[%0d] got u=%b s=%b want one-hot", i, {u_lt, u_gt, u_eq}, {s_lt, s_gt, s_eq});
      else passes++;
    end
  endtask

  task automatic test_signed();
    logic [7:0] av[4] = '{8'hFF, 8'h80, 8'h7F, 8'h80};
    logic [7:0] bv[4] = '{8'h01, 8'h7F, 8'h80, 8'h80};
    logic [3:0] cv[4] = '{4'b1100, 4'b1100, 4'b1010, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = av[i]; b = bv[i];
      tick();
      checks++;
      if ({s_ov, s_lt, s_gt, s_eq} !== cv[i])
        $display("FAIL signed[%0d] got %b want %b", i, {s_ov, s_lt, s_gt, s_eq}, cv[i]);
      else passes++;
    end
  endtask

  task automatic test_valid_gaps();
    logic [3:0] cv[5] = '{4'b1100, 4'b0100, 4'b0100, 4'b1010, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin in_valid = 1'b1; a = 8'd10; b = 8'd20; end
        1, 2: begin in_valid = 1'b0; a = 8'd99; b = 8'd1; end
        3: begin in_valid = 1'b1; a = 8'd30; b = 8'd5; end
        default: begin rst = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd2; end
      endcase
      tick();
      checks++;
      if ({u_ov, u_lt, u_gt, u_eq} !== cv[i])
        $display("FAIL valid_gaps[%0d] got %b want %b", i, {u_ov, u_lt, u_gt, u_eq}, cv[i]);
      else passes++;
`ifdef N_BIT_COMPARATOR_DIFF_EN
      checks++;
      if (u_diff !== exd_u)
        $display("FAIL valid_gaps_diff[%0d] got %0d want %0d", i, u_diff, exd_u);
      else passes++;
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = ($urandom_range(0, 4) == 0) ? a : 8'($urandom);
      tick();
      checks++;
      if ({u_ov, u_lt, u_gt, u_eq} !== exp_u || {s_ov, s_lt, s_gt, s_eq} !== exp_s)
        $display("FAIL random[%0d] got u=%b s=%b want u=%b s=%b", i,
                 {u_ov, u_lt, u_gt, u_eq}, {s_ov, s_lt, s_gt, s_eq}, exp_u, exp_s);
      else passes++;
`ifdef N_BIT_COMPARATOR_DIFF_EN
      checks++;
      if (u_diff !== exd_u || s_diff !== exd_s)
        $display("FAIL random_diff[%0d] got u=%0d s=%0d want u=%0d s=%0d", i, u_diff, s_diff, exd_u, exd_s);
      else passes++;
`endif
    end
  endtask

`ifdef N_BIT_COMPARATOR_DIFF_EN
  task automatic test_diff();
    in_valid = 1'b1; a = 8'd111; b = 8'd250;
    tick();
    checks++;
    if (u_diff !== 8'd139) $display("FAIL diff_111_250 got %0d want 139", u_diff);
    else passes++;
    a = 8'd147; b = 8'd103;
    tick();
    checks++;
    if (u_diff !== 8'd44) $display("FAIL diff_147_103 got %0d want 44", u_diff);
    else passes++;
    a = 8'hFF; b = 8'h01;
    tick();
    checks++;
    if (s_diff !== 8'd2) $display("FAIL diff_signed_ff_01 got %0d want 2", s_diff);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_seq();
    test_boundaries();
    test_signed();
    test_valid_gaps();
    test_random();
`ifdef N_BIT_COMPARATOR_DIFF_EN
    test_diff();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
